receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter OSR, default 16, meaning oversample ticks per bit; legal values are even and 4..16.
REQ-002 clk  input  1  sole clock; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 os_tick  input  1  single-cycle pulse at OSR x baud rate.
REQ-005 rx_in  input  1  asynchronous UART serial line, idles high.
REQ-006 rd_en  input  1  consumer pulse that acknowledges data_out.
REQ-007 data_out  output  8  last correctly framed byte.
REQ-008 data_valid  output  1  data_out holds an unread byte.
REQ-009 frame_err  output  1  single-cycle pulse when the stop bit is sampled low.
REQ-010 overrun  output  1  single-cycle pulse when an unread byte is overwritten.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer (rx_s); a further flop rx_p SHALL hold the previous rx_s for edge detection.
REQ-013 Frame format SHALL be 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); no parity.
REQ-014 State machine SHALL have states IDLE, START, DATA, STOP; sample_cnt is log2(OSR) bits; bit_cnt is 3 bits.
REQ-015 IDLE: when rx_p=1 and rx_s=0 (falling edge), go to START and set sample_cnt=0; a line held low SHALL NOT retrigger.
REQ-016 START: sample_cnt increments on each os_tick; on the tick where sample_cnt=OSR/2-1, rx_s=0 goes to DATA with sample_cnt=0 and bit_cnt=0, and rx_s=1 (glitch) goes to IDLE with no output change.
REQ-017 DATA: sample_cnt increments on each os_tick and wraps; on the tick where sample_cnt=OSR-1, rx_s shifts into shreg MSB (right shift) and bit_cnt increments; on that tick with bit_cnt=7, go to STOP.
REQ-018 STOP: on the tick where sample_cnt=OSR-1, the next state SHALL be IDLE; rx_s=1 loads data_out<=shreg and sets data_valid=1; rx_s=0 pulses frame_err for one cycle and leaves data_out and data_valid unchanged.
REQ-019 Without os_tick, counters and state SHALL hold, except IDLE edge detection, which SHALL run every clk.
REQ-020 data_valid SHALL clear on the clk after rd_en=1; rd_en with data_valid=0 SHALL be ignored.
REQ-021 A good stop while data_valid=1 and rd_en=0 SHALL overwrite data_out, keep data_valid=1, and pulse overrun for one cycle.
REQ-022 A good stop in the same cycle as rd_en SHALL load the new byte, keep data_valid=1, and not pulse overrun.
REQ-023 Latency: data_valid SHALL rise 1 clk after the stop-bit sample tick.
REQ-024 Each bit SHALL be sampled at its centre (OSR/2 ticks after the detected start edge, plus a multiple of OSR).

Reset
REQ-025 rst=1 at a clk edge SHALL force state=IDLE, sample_cnt=0, bit_cnt=0, shreg=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, and rx_s=rx_p=1 (synchronizer flops).
REQ-026 rst asserted mid-frame SHALL abandon the frame; after release, the receiver SHALL wait for a fresh falling edge.

Structure
REQ-027 The rx_state_t enum (IDLE, START, DATA, STOP) SHALL live in the shared package uart_pkg, alongside the transmitter state enum.
REQ-028 The synchronizer SHALL be a sub-module sync2 (parameterised reset value 1) so the serial path can reuse it.
REQ-029 A single always_ff for registers and a single always_comb for next-state logic; no latches.

Verification
REQ-030 Send byte 0xA5 with OSR=16 -> data_out=0xA5, data_valid=1 one clk after the stop sample, frame_err=0.
REQ-031 Pulse rx_in low for 4 os_ticks then return high -> state returns to IDLE, data_valid stays 0, no frame_err.
REQ-032 Send 0x3C with the stop bit driven low -> frame_err pulses exactly 1 cycle, data_valid=0, and the next good frame 0x55 is received correctly.
REQ-033 Send 0x11 then 0x22 without rd_en -> overrun pulses once and data_out=0x22; repeat with rd_en on the completion cycle -> no overrun.
REQ-034 Assert rst during bit 4 of 0xFF, hold rx_in low, then release -> no byte is produced and no spurious start occurs until rx_in goes high then low.
REQ-035 Loopback: transmitter tx_out to rx_in, sending bytes 0x00, 0xFF, 0x80 and 0x01 -> each byte received identically, with os_tick at 16x the transmitter's baud_tick.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receive path and the transmit path:
//   rx_state_t    - receiver frame state machine encoding
//   tx_state_t    - transmitter frame state machine encoding
//   UART_DATA_BITS - payload width of one frame
//   shift_in_msb() - LSB-first deserialiser step (new bit enters at the MSB)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Data arrives LSB first, so each sampled bit enters at the top and the
    // register shifts right; after eight samples bit 0 sits at position 0.
    function automatic logic [7:0] shift_in_msb(input logic [7:0] sh, input logic b);
        return {b, sh[7:1]};
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous level.
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, loads RST_VAL into both flops
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clocks of latency)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Synchroniser shift register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {RST_VAL, RST_VAL};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
// Oversampling UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   os_tick    - one-cycle pulse at OSR x baud
//   rx_in      - asynchronous serial line, idles high
//   rd_en      - consumer acknowledge of data_out
//   data_out   - last correctly framed byte
//   data_valid - data_out holds an unread byte
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   overrun    - one-cycle pulse when an unread byte is overwritten
//   busy       - high whenever a frame is in progress
// -----------------------------------------------------------------------------
module receiver
    import uart_pkg::*;
#(
    parameter int OSR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       os_tick,
    input  logic       rx_in,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

    logic          rx_s;
    logic          rx_p_q;
    rx_state_t     state_q,      state_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]    bit_cnt_q,    bit_cnt_d;
    logic [7:0]    shreg_q,      shreg_d;
    logic [7:0]    data_out_q,   data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q,  frame_err_d;
    logic          overrun_q,    overrun_d;
    logic          busy_q,       busy_d;
    logic [2:0]    arm_q,        arm_d;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    // All receiver state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p_q       <= 1'b1;
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            arm_q        <= 3'b000;
        end else begin
            rx_p_q       <= rx_s;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            arm_q        <= arm_d;
        end
    end

    // Next-state and output logic for the frame state machine
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        // The synchroniser and rx_p come out of reset forced high. If the line
        // is really low, that forced 1 followed by the true 0 would look like a
        // start edge. Edge detection is held off until three clocks after
        // reset, by which point rx_s and rx_p both carry real line samples.
        arm_d        = {arm_q[1:0], 1'b1};

        if (rd_en && data_valid_q) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        case (state_q)
            IDLE: begin
                // Edge detection runs every clk, independent of os_tick.
                if (arm_q[2] && rx_p_q && !rx_s) begin
                    state_d      = START;
                    sample_cnt_d = '0;
                end else begin
                    state_d      = IDLE;
                end
            end

            START: begin
                if (os_tick) begin
                    if (sample_cnt_q == CNT_HALF) begin
                        sample_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = 3'd0;
                        end else begin
                            // Line went back high before mid-bit: glitch.
                            state_d   = IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = START;
                end
            end

            DATA: begin
                if (os_tick) begin
                    if (sample_cnt_q == CNT_LAST) begin
                        sample_cnt_d = '0;
                        shreg_d      = shift_in_msb(shreg_q, rx_s);
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end

            STOP: begin
                if (os_tick) begin
                    if (sample_cnt_q == CNT_LAST) begin
                        state_d      = IDLE;
                        sample_cnt_d = '0;
                        if (rx_s) begin
                            data_out_d   = shreg_q;
                            data_valid_d = 1'b1;
                            // A same-cycle rd_en consumes the old byte, so
                            // nothing unread is lost.
                            overrun_d    = data_valid_q && !rd_en;
                        end else begin
                            frame_err_d  = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = STOP;
                end
            end

            default: begin
                state_d      = IDLE;
                sample_cnt_d = '0;
                bit_cnt_d    = 3'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_receiver.sv
// -----------------------------------------------------------------------------
// tb_receiver
// Directed, table-driven bench for the UART receiver (OSR = 16, one os_tick
// every four clocks, so one bit lasts 64 clocks).
// -----------------------------------------------------------------------------
module tb_receiver;

    localparam int OSR        = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OSR * TICK_DIV;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
    // Ticks after the start-edge detection to the stop-bit sample:
    // half a bit to the start centre, then 8 data bits and the stop bit.
    localparam int STOP_TICKS = OSR / 2 + 9 * OSR;

    logic       clk = 1'b0;
    logic       rst;
    logic       os_tick;
    logic       rx_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_phase = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       rd_before;
        logic       rd_at_done;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
        int         exp_ov;
        logic       chk_lat;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] lb_q[$];
    int lb_got = 0;

    receiver #(.OSR(OSR)) dut (
        .clk        (clk),
        .rst        (rst),
        .os_tick    (os_tick),
        .rx_in      (rx_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and drive the free-running os_tick.
    task automatic step();
        @(negedge clk);
        tick_phase = (tick_phase + 1) % TICK_DIV;
        os_tick    = (tick_phase == 0);
    endtask

    task automatic rd_pulse();
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    // Send one frame timed in clocks; find the stop-sample edge by counting
    // ticks from the start-edge detection edge (third posedge after the drop).
    task automatic run_frame(input vec_t v, output int fe_n, output int ov_n,
                             output logic pre_v, output logic post_v, output logic found);
        logic [9:0] fr;
        int ticks;
        int done_c;
        fr     = {v.stop_ok, v.data, 1'b0};
        ticks  = 0;
        done_c = -1;
        fe_n   = 0;
        ov_n   = 0;
        pre_v  = 1'b0;
        post_v = 1'b0;
        found  = 1'b0;
        for (int c = 0; c < FRAME_CLKS + BIT_CLKS; c++) begin
            step();
            fe_n += int'(frame_err);
            ov_n += int'(overrun);
            if (done_c >= 0 && c == done_c + 1) post_v = data_valid;
            rx_in = (c < FRAME_CLKS) ? fr[c / BIT_CLKS] : 1'b1;
            rd_en = 1'b0;
            if (c + 1 > 3 && os_tick) begin
                ticks++;
                if (ticks == STOP_TICKS) begin
                    done_c = c;
                    found  = 1'b1;
                    pre_v  = data_valid;
                    rd_en  = v.rd_at_done;
                end
            end
        end
        rd_en = 1'b0;
    endtask

    // Loopback consumer: acknowledge each byte and compare it to what was sent.
    task automatic lb_monitor();
        if (rd_en) begin
            rd_en = 1'b0;
        end else if (data_valid) begin
            lb_got++;
            if (lb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lb_extra: got unexpected byte 0x%0h", data_out);
            end else begin
                check("lb_data", data_out, lb_q.pop_front());
            end
            rd_en = 1'b1;
        end
    endtask

    // Behavioural transmitter: baud tick = every OSR os_ticks.
    task automatic tx_send(input logic [7:0] b);
        logic [9:0] fr;
        int n;
        fr = {1'b1, b, 1'b0};
        lb_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx_in = fr[i];
            n = 0;
            while (n < OSR) begin
                step();
                lb_monitor();
                if (os_tick) n++;
            end
        end
    endtask

    initial begin
        int   fe_n, ov_n;
        logic pre_v, post_v, found;
        logic busy_seen;
        logic [9:0] fr;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 0, 0, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 0, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 0, 0, 1'b1};
        vecs[3] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0, 1'b1};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 0, 1, 1'b0};
        vecs[5] = '{8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 0, 0, 1'b0};
        vecs[6] = '{8'h44, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1, 0, 1'b0};

        rst     = 1'b1;
        os_tick = 1'b0;
        rx_in   = 1'b1;
        rd_en   = 1'b0;
        repeat (4) step();
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (8) step();

        // Short low glitch (4 ticks) must be rejected at the start centre.
        busy_seen = 1'b0;
        fe_n      = 0;
        rx_in     = 1'b0;
        repeat (4 * TICK_DIV) begin
            step();
            busy_seen |= busy;
        end
        rx_in = 1'b1;
        repeat (BIT_CLKS) begin
            step();
            busy_seen |= busy;
            fe_n += int'(frame_err);
        end
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_idle", busy, 1'b0);
        check("glitch_valid", data_valid, 1'b0);
        check("glitch_fe", fe_n, 0);

        // Table of frames; state carries from one vector to the next.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rd_before) begin
                rd_pulse();
                check("rd_clear", data_valid, 1'b0);
            end
            run_frame(vecs[i], fe_n, ov_n, pre_v, post_v, found);
            check("stop_tick_found", found, 1'b1);
            check("data_out", data_out, vecs[i].exp_data);
            check("data_valid", data_valid, vecs[i].exp_valid);
            check("frame_err_cycles", fe_n, vecs[i].exp_fe);
            check("overrun_cycles", ov_n, vecs[i].exp_ov);
            check("busy_after", busy, 1'b0);
            if (vecs[i].chk_lat) begin
                check("lat_valid_before", pre_v, 1'b0);
                check("lat_valid_after", post_v, 1'b1);
            end
        end

        // rd_en clears data_valid; a second rd_en with nothing unread is ignored.
        rd_pulse();
        check("rd_clear_final", data_valid, 1'b0);
        rd_pulse();
        check("rd_idle_valid", data_valid, 1'b0);
        check("rd_idle_data", data_out, 8'h33);

        // Reset in the middle of 0xFF with the line then held low.
        fr = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 4 * BIT_CLKS + 20 + BIT_CLKS; c++) begin
            step();
            rx_in = fr[c / BIT_CLKS];
        end
        check("midframe_busy", busy, 1'b1);
        rx_in = 1'b0;
        rst   = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("mid_rst_data_out", data_out, 8'h00);
        check("mid_rst_valid", data_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        busy_seen = 1'b0;
        fe_n      = 0;
        repeat (1000) begin
            step();
            busy_seen |= busy;
            fe_n += int'(frame_err);
        end
        check("held_low_no_start", busy_seen, 1'b0);
        check("held_low_valid", data_valid, 1'b0);
        check("held_low_fe", fe_n, 0);
        rx_in = 1'b1;
        repeat (BIT_CLKS) step();
        run_frame('{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 0, 0, 1'b1},
                  fe_n, ov_n, pre_v, post_v, found);
        check("after_rst_data", data_out, 8'h5A);
        check("after_rst_valid", data_valid, 1'b1);
        check("after_rst_lat", post_v, 1'b1);

        // Loopback from the transmitter model, back-to-back frames.
        rd_pulse();
        fe_n = 0;
        tx_send(8'h00);
        tx_send(8'hFF);
        tx_send(8'h80);
        tx_send(8'h01);
        rx_in = 1'b1;
        repeat (200) begin
            step();
            lb_monitor();
            fe_n += int'(frame_err);
        end
        check("lb_count", lb_got, 4);
        check("lb_pending", lb_q.size(), 0);
        check("lb_fe", fe_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
